// File: rtl/duck_shot_eval.sv
// duck_shot_eval: debounces the gun trigger, judges each shot against the duck hit box, tracks ammo and score
module duck_shot_eval #(
  parameter int DUCK_W          = 64,
  parameter int DUCK_H          = 64,
  parameter int SHOTS           = 3,
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int HIT_HOLD_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame,
  input  logic        round_start,
  input  logic        trigger,
  input  logic [10:0] aim_x,
  input  logic [10:0] aim_y,
  input  logic [10:0] duck_x,
  input  logic [10:0] duck_y,
  input  logic        duck_show,
  output logic        shot_fired,
  output logic        shot_miss,
  output logic        duck_hit,
  output logic        out_of_ammo,
  output logic [1:0]  bullets_left,
  output logic [3:0]  hits
);
  typedef enum logic [2:0] {IDLE, ARMED, EVAL, HIT_HOLD, EMPTY} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(HIT_HOLD_FRAMES + 1);
  state_t state, state_n;
  logic s1, trig_s, trig_db, trig_db_q, press, in_box;
  logic hit_r, hit_n, fired_n, miss_n;
  logic [CW-1:0] db_cnt;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic [1:0] bullets_n;
  logic [3:0] hits_n;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 1'b0;
      trig_s <= 1'b0;
      trig_db <= 1'b0;
      trig_db_q <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= trigger;
      trig_s <= s1;
      trig_db_q <= trig_db;
      if (trig_s == trig_db) db_cnt <= '0;
      else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        trig_db <= trig_s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  assign press = trig_db & ~trig_db_q;
  // 12-bit sums keep a duck near the right/bottom edge from wrapping its box
  assign in_box = duck_show &&
                  {1'b0, aim_x} >= {1'b0, duck_x} && {1'b0, aim_x} < {1'b0, duck_x} + 12'(DUCK_W) &&
                  {1'b0, aim_y} >= {1'b0, duck_y} && {1'b0, aim_y} < {1'b0, duck_y} + 12'(DUCK_H);
  always_comb begin
    state_n = state;
    bullets_n = bullets_left;
    hits_n = hits;
    frame_cnt_n = frame_cnt;
    hit_n = hit_r;
    fired_n = 1'b0;
    miss_n = 1'b0;
    if (round_start) begin
      state_n = ARMED;
      bullets_n = 2'(SHOTS);
    end else
      case (state)
        ARMED:
          if (press && bullets_left != 2'd0) begin
            fired_n = 1'b1;
            bullets_n = bullets_left - 1'b1;
            hit_n = in_box;
            state_n = EVAL;
          end
        EVAL:
          if (hit_r) begin
            hits_n = (hits == 4'd15) ? hits : hits + 1'b1;
            frame_cnt_n = '0;
            state_n = HIT_HOLD;
          end else begin
            miss_n = 1'b1;
            state_n = (bullets_left == 2'd0) ? EMPTY : ARMED;
          end
        HIT_HOLD:
          if (new_frame) begin
            frame_cnt_n = frame_cnt + 1'b1;
            state_n = (frame_cnt == FW'(HIT_HOLD_FRAMES - 1)) ? IDLE : HIT_HOLD;
          end
        default: ;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bullets_left <= 2'd0;
      hits <= 4'd0;
      frame_cnt <= '0;
      hit_r <= 1'b0;
      shot_fired <= 1'b0;
      shot_miss <= 1'b0;
      duck_hit <= 1'b0;
      out_of_ammo <= 1'b0;
    end else begin
      state <= state_n;
      bullets_left <= bullets_n;
      hits <= hits_n;
      frame_cnt <= frame_cnt_n;
      hit_r <= hit_n;
      shot_fired <= fired_n;
      shot_miss <= miss_n;
      duck_hit <= state_n == HIT_HOLD;
      out_of_ammo <= state_n == EMPTY;
    end
endmodule
